write_back: RTL and testbench

WRITE_BACK -- requirements
Module: write_back

---
 rtl/write_back.sv | 144 ++++++++++++++
 tb/tb_write_back.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/write_back.sv
// Write-back stage: W pipeline register, architectural register file,
// sticky halt flag and retired-instruction counter.
module write_back #(
    parameter int XLEN  = 64,
    parameter int NREGS = 15
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            W_stall_i,
    input  logic            W_bubble_i,
    input  logic [3:0]      M_icode_i,
    input  logic [2:0]      M_stat_i,
    input  logic [XLEN-1:0] M_valE_i,
    input  logic [XLEN-1:0] m_valM_i,
    input  logic [3:0]      M_dstE_i,
    input  logic [3:0]      M_dstM_i,
    input  logic [3:0]      d_srcA_i,
    input  logic [3:0]      d_srcB_i,
    output logic [XLEN-1:0] d_rvalA_o,
    output logic [XLEN-1:0] d_rvalB_o,
    output logic [3:0]      W_dstE_o,
    output logic [3:0]      W_dstM_o,
    output logic [XLEN-1:0] W_valE_o,
    output logic [XLEN-1:0] W_valM_o,
    output logic [3:0]      W_icode_o,
    output logic [2:0]      stat_o,
    output logic            halted_o,
    output logic [31:0]     retire_cnt_o
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] INOP  = 4'h1;
    localparam logic [2:0] SAOK  = 3'd1;
    localparam logic [2:0] SHLT  = 3'd2;
    localparam logic [2:0] SADR  = 3'd3;
    localparam logic [2:0] SINS  = 3'd4;

    logic            w_valid_q;
    logic [3:0]      w_icode_q;
    logic [2:0]      w_stat_q;
    logic [XLEN-1:0] w_valE_q;
    logic [XLEN-1:0] w_valM_q;
    logic [3:0]      w_dstE_q;
    logic [3:0]      w_dstM_q;

    logic            halted_q;
    logic [31:0]     retire_cnt_q;
    logic            counted_q;

    logic [XLEN-1:0] regs_rd [NREGS];

    logic retire_ok;
    logic fault;

    assign retire_ok = w_valid_q && (w_stat_q == SAOK) && !halted_q;
    assign fault     = w_valid_q &&
                       ((w_stat_q == SHLT) || (w_stat_q == SADR) || (w_stat_q == SINS));

    // Stall has priority over bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_valid_q <= 1'b0;
            w_icode_q <= INOP;
            w_stat_q  <= SAOK;
            w_valE_q  <= '0;
            w_valM_q  <= '0;
            w_dstE_q  <= RNONE;
            w_dstM_q  <= RNONE;
        end else if (!W_stall_i) begin
            if (W_bubble_i) begin
                w_valid_q <= 1'b0;
                w_icode_q <= INOP;
                w_stat_q  <= SAOK;
                w_valE_q  <= '0;
                w_valM_q  <= '0;
                w_dstE_q  <= RNONE;
                w_dstM_q  <= RNONE;
            end else begin
                w_valid_q <= 1'b1;
                w_icode_q <= M_icode_i;
                w_stat_q  <= M_stat_i;
                w_valE_q  <= M_valE_i;
                w_valM_q  <= m_valM_i;
                w_dstE_q  <= M_dstE_i;
                w_dstM_q  <= M_dstM_i;
            end
        end
    end

    // One register per ID; port M is checked first so it wins on a shared destination.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        logic [XLEN-1:0] r_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_q <= '0;
            end else if (retire_ok && (w_dstM_q == 4'(gi))) begin
                r_q <= w_valM_q;
            end else if (retire_ok && (w_dstE_q == 4'(gi))) begin
                r_q <= w_valE_q;
            end
        end

        assign regs_rd[gi] = r_q;
    end

    always_comb begin
        d_rvalA_o = '0;
        d_rvalB_o = '0;
        if ((d_srcA_i != RNONE) && (int'(d_srcA_i) < NREGS)) begin
            d_rvalA_o = regs_rd[d_srcA_i];
        end
        if ((d_srcB_i != RNONE) && (int'(d_srcB_i) < NREGS)) begin
            d_rvalB_o = regs_rd[d_srcB_i];
        end
    end

    // counted_q remembers that the instruction held in W was already counted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retire_cnt_q <= '0;
            counted_q    <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            if (retire_ok && !counted_q) begin
                retire_cnt_q <= retire_cnt_q + 32'd1;
            end
            counted_q <= W_stall_i && (counted_q || retire_ok);
            if (fault) begin
                halted_q <= 1'b1;
            end
        end
    end

    assign W_dstE_o     = w_dstE_q;
    assign W_dstM_o     = w_dstM_q;
    assign W_valE_o     = w_valE_q;
    assign W_valM_o     = w_valM_q;
    assign W_icode_o    = w_icode_q;
    assign stat_o       = w_stat_q;
    assign halted_o     = halted_q;
    assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: expected register writes are queued
// when an instruction is driven and compared once it has passed through W.
module tb_write_back;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        W_stall_i, W_bubble_i;
    logic [3:0]  M_icode_i;
    logic [2:0]  M_stat_i;
    logic [63:0] M_valE_i, m_valM_i;
    logic [3:0]  M_dstE_i, M_dstM_i, d_srcA_i, d_srcB_i;
    logic [63:0] d_rvalA_o, d_rvalB_o, W_valE_o, W_valM_o;
    logic [3:0]  W_dstE_o, W_dstM_o, W_icode_o;
    logic [2:0]  stat_o;
    logic        halted_o;
    logic [31:0] retire_cnt_o;

    write_back #(.XLEN(64), .NREGS(15)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .W_stall_i(W_stall_i), .W_bubble_i(W_bubble_i),
        .M_icode_i(M_icode_i), .M_stat_i(M_stat_i), .M_valE_i(M_valE_i), .m_valM_i(m_valM_i),
        .M_dstE_i(M_dstE_i), .M_dstM_i(M_dstM_i), .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i),
        .d_rvalA_o(d_rvalA_o), .d_rvalB_o(d_rvalB_o), .W_dstE_o(W_dstE_o), .W_dstM_o(W_dstM_o),
        .W_valE_o(W_valE_o), .W_valM_o(W_valM_o), .W_icode_o(W_icode_o), .stat_o(stat_o),
        .halted_o(halted_o), .retire_cnt_o(retire_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  rid;
        logic [63:0] val;
    } wr_exp_t;

    wr_exp_t     exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_cnt  = 0;
    bit          exp_halted = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        W_stall_i  = 1'b0;
        W_bubble_i = 1'b1;
    endtask

    // Drive one instruction from M and queue the register writes it should make.
    task automatic drive_m(input logic [3:0] icode, input logic [2:0] stat,
                           input logic [3:0] dste, input logic [3:0] dstm,
                           input logic [63:0] vale, input logic [63:0] valm);
        W_stall_i  = 1'b0;
        W_bubble_i = 1'b0;
        M_icode_i  = icode;
        M_stat_i   = stat;
        M_dstE_i   = dste;
        M_dstM_i   = dstm;
        M_valE_i   = vale;
        m_valM_i   = valm;
        if (stat == 3'd1 && !exp_halted) begin
            if (dste != 4'hF && dste != dstm) exp_q.push_back('{rid: dste, val: vale});
            if (dstm != 4'hF) exp_q.push_back('{rid: dstm, val: valm});
        end
        $display("drive icode=%0d stat=%0d dstE=%0d dstM=%0d valE=%h valM=%h",
                 icode, stat, dste, dstm, vale, valm);
    endtask

    task automatic drain();
        wr_exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            d_srcA_i = e.rid;
            d_srcB_i = e.rid;
            #1;
            $display("readback r%0d A=%h B=%h", e.rid, d_rvalA_o, d_rvalB_o);
            chk($sformatf("rvalA_r%0d", e.rid), d_rvalA_o, e.val);
            chk($sformatf("rvalB_r%0d", e.rid), d_rvalB_o, e.val);
        end
    endtask

    task automatic read_reg(input string tag, input logic [3:0] rid, input logic [63:0] exp);
        d_srcA_i = rid;
        #1;
        chk(tag, d_rvalA_o, exp);
    endtask

    initial begin
        logic [3:0]  rde, rdm;
        logic [63:0] ve, vm;
        rst_i = 1'b1;
        idle();
        M_icode_i = 4'h1; M_stat_i = 3'd1; M_dstE_i = 4'hF; M_dstM_i = 4'hF;
        M_valE_i = '0; m_valM_i = '0; d_srcA_i = 4'hF; d_srcB_i = 4'hF;
        #2;
        chk("rst_cnt", 64'(retire_cnt_o), 64'd0);
        chk("rst_halted", 64'(halted_o), 64'd0);
        chk("rst_stat", 64'(stat_o), 64'd1);
        chk("rst_icode", 64'(W_icode_o), 64'h1);
        chk("rst_dstE", 64'(W_dstE_o), 64'hF);
        chk("rst_rnone_B", d_rvalB_o, 64'd0);
        tick();
        rst_i = 1'b0;

        // Single register write, two-edge visibility
        drive_m(4'h2, 3'd1, 4'd3, 4'hF, 64'h1234, 64'h0);
        tick();
        chk("w_dstE", 64'(W_dstE_o), 64'd3);
        chk("w_valE", W_valE_o, 64'h1234);
        chk("w_icode", 64'(W_icode_o), 64'h2);
        chk("cnt_before_retire", 64'(retire_cnt_o), 64'd0);
        idle(); tick(); exp_cnt++;
        chk("cnt_first", 64'(retire_cnt_o), 64'(exp_cnt));
        drain();

        // Both ports to the same register: M wins
        drive_m(4'h5, 3'd1, 4'd4, 4'd4, 64'h8, 64'hAA);
        tick(); idle(); tick(); exp_cnt++;
        chk("cnt_dual", 64'(retire_cnt_o), 64'(exp_cnt));
        drain();

        // Random dual writes into registers 11..14
        for (int i = 0; i < 4; i++) begin
            rde = 4'($urandom_range(11, 14));
            rdm = 4'($urandom_range(11, 15));
            ve  = {$urandom, $urandom};
            vm  = {$urandom, $urandom};
            drive_m(4'h6, 3'd1, rde, rdm, ve, vm);
            tick(); idle(); tick(); exp_cnt++;
            chk("cnt_rand", 64'(retire_cnt_o), 64'(exp_cnt));
            drain();
        end

        // Held instruction repeats its write but counts once
        drive_m(4'h2, 3'd1, 4'd2, 4'hF, 64'h5, 64'h0);
        tick();
        W_stall_i = 1'b1; M_dstE_i = 4'd7; M_valE_i = 64'h77;
        repeat (3) tick();
        exp_cnt++;
        chk("stall_hold_dstE", 64'(W_dstE_o), 64'd2);
        chk("stall_cnt", 64'(retire_cnt_o), 64'(exp_cnt));
        idle(); tick();
        chk("stall_release_cnt", 64'(retire_cnt_o), 64'(exp_cnt));
        drain();
        read_reg("stall_r7_untouched", 4'd7, 64'd0);

        // Stall beats bubble; bubble alone clears W
        drive_m(4'h6, 3'd1, 4'd8, 4'hF, 64'h88, 64'h0);
        tick();
        W_stall_i = 1'b1; W_bubble_i = 1'b1;
        M_icode_i = 4'h3; M_dstE_i = 4'd9; M_valE_i = 64'h99;
        tick(); exp_cnt++;
        chk("sb_dstE", 64'(W_dstE_o), 64'd8);
        chk("sb_icode", 64'(W_icode_o), 64'h6);
        chk("sb_valE", W_valE_o, 64'h88);
        idle(); tick();
        chk("bub_icode", 64'(W_icode_o), 64'h1);
        chk("bub_dstE", 64'(W_dstE_o), 64'hF);
        chk("bub_dstM", 64'(W_dstM_o), 64'hF);
        chk("bub_valE", W_valE_o, 64'd0);
        chk("bub_cnt", 64'(retire_cnt_o), 64'(exp_cnt));
        tick();
        chk("bub_nocount", 64'(retire_cnt_o), 64'(exp_cnt));
        drain();

        // Address fault halts the machine; nothing after it writes or counts
        drive_m(4'h5, 3'd3, 4'd1, 4'hF, 64'h9, 64'h0);
        tick();
        chk("fault_stat", 64'(stat_o), 64'd3);
        chk("fault_not_yet_halted", 64'(halted_o), 64'd0);
        exp_halted = 1;
        drive_m(4'h2, 3'd1, 4'd10, 4'hF, 64'hAB, 64'h0);
        tick();
        chk("halted_set", 64'(halted_o), 64'd1);
        idle(); tick();
        chk("halted_sticky", 64'(halted_o), 64'd1);
        chk("halted_stat_bubble", 64'(stat_o), 64'd1);
        chk("halted_cnt", 64'(retire_cnt_o), 64'(exp_cnt));
        read_reg("fault_r1", 4'd1, 64'd0);
        read_reg("halted_r10", 4'd10, 64'd0);

        // Asynchronous reset between edges
        #2 rst_i = 1'b1;
        #1 rst_i = 1'b0;
        exp_cnt = 0; exp_halted = 0; exp_q.delete();
        chk("arst_cnt", 64'(retire_cnt_o), 64'd0);
        chk("arst_halted", 64'(halted_o), 64'd0);
        for (int r = 0; r < 15; r++) begin
            d_srcA_i = 4'(r);
            #0.1;
            chk($sformatf("arst_r%0d", r), d_rvalA_o, 64'd0);
        end
        @(negedge clk_i);
        drive_m(4'h2, 3'd1, 4'd3, 4'hF, 64'h77, 64'h0);
        tick(); idle(); tick(); exp_cnt++;
        chk("post_rst_cnt", 64'(retire_cnt_o), 64'(exp_cnt));
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
